// File: rtl/serial_comp_seq_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding,
// slice width and the index-width helper.
package serial_comp_seq_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Index register width; a single-slice operand still needs one bit.
    function automatic int idx_width(input int slices);
        if (slices > 1) begin
            return $clog2(slices);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_comp_seq_if.sv
// Request/result bundle of serial_comp_seq: the master issues start with two
// operands, the slave returns busy/done and the held greater/lesser/equal flags.
interface serial_comp_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             lesser;
    logic             equal;

    modport master (
        output start, a, b,
        input  busy, done, greater, lesser, equal
    );

    modport slave (
        input  start, a, b,
        output busy, done, greater, lesser, equal
    );
endinterface

// File: rtl/serial_comp_seq_comp_gate.sv
// comp_gate: existing 2-bit gate-level magnitude comparator, purely combinational.
module comp_gate
    import serial_comp_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               greater,
    output logic               lesser,
    output logic               equal
);
    logic eq_hi_s;
    logic eq_lo_s;

    assign eq_hi_s = ~(a[1] ^ b[1]);
    assign eq_lo_s = ~(a[0] ^ b[0]);

    // The low bit only decides when the high bits tie.
    assign greater = (a[1] & ~b[1]) | (eq_hi_s & a[0] & ~b[0]);
    assign lesser  = (~a[1] & b[1]) | (eq_hi_s & ~a[0] & b[0]);
    assign equal   = eq_hi_s & eq_lo_s;
endmodule

// File: rtl/serial_comp_seq.sv
// serial_comp_seq: WIDTH-bit magnitude comparator that walks comp_gate over
// 2-bit slices, MSB first. Macro SERIAL_COMP_EARLY_EXIT_EN stops at the first
// differing slice; without it every slice is scanned and latency is fixed.
module serial_comp_seq
    import serial_comp_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_comp_seq_if.slave   bus
);
    localparam int S     = WIDTH / SLICE_W;
    localparam int IDX_W = idx_width(S);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(S - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e             state_q,   state_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic               greater_q, greater_d;
    logic               lesser_q,  lesser_d;
    logic               equal_q,   equal_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
    logic               decided_q, decided_d;
`endif

    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic               slice_gt_s;
    logic               slice_lt_s;
    logic               slice_eq_s;

    assign slice_a_s = a_q[SLICE_W*idx_q +: SLICE_W];
    assign slice_b_s = b_q[SLICE_W*idx_q +: SLICE_W];

    comp_gate u_comp_gate (
        .a       (slice_a_s),
        .b       (slice_b_s),
        .greater (slice_gt_s),
        .lesser  (slice_lt_s),
        .equal   (slice_eq_s)
    );

    // Next-state, index, operand and result computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        greater_d = greater_q;
        lesser_d  = lesser_q;
        equal_d   = equal_q;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
        decided_d = decided_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    idx_d     = IDX_LAST;
                    greater_d = 1'b0;
                    lesser_d  = 1'b0;
                    equal_d   = 1'b0;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
                    decided_d = 1'b0;
`endif
                    state_d   = ST_CMP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CMP: begin
`ifdef SERIAL_COMP_EARLY_EXIT_EN
                if (!slice_eq_s) begin
                    greater_d = slice_gt_s;
                    lesser_d  = slice_lt_s;
                    state_d   = ST_DONE;
                end else if (idx_q == IDX_ZERO) begin
                    equal_d   = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    idx_d     = idx_q - IDX_ONE;
                end
`else
                // Only the most significant differing slice may set the result.
                if (!decided_q && !slice_eq_s) begin
                    greater_d = slice_gt_s;
                    lesser_d  = slice_lt_s;
                    decided_d = 1'b1;
                end else begin
                    decided_d = decided_q;
                end
                if (idx_q == IDX_ZERO) begin
                    equal_d   = !decided_q && slice_eq_s;
                    state_d   = ST_DONE;
                end else begin
                    idx_d     = idx_q - IDX_ONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags follow the next state so they are registered, not decoded.
        busy_d = (state_d == ST_CMP) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // FSM and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_ZERO;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
            decided_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            greater_q <= greater_d;
            lesser_q  <= lesser_d;
            equal_q   <= equal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
            decided_q <= decided_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.greater = greater_q;
    assign bus.lesser  = lesser_q;
    assign bus.equal   = equal_q;

endmodule

// File: doc/serial_comp_seq.md
# serial_comp_seq

Sequential N-bit magnitude comparator built on the existing 2-bit gate-level comparator `comp_gate`. On a start strobe it captures two WIDTH-bit operands and feeds `comp_gate` one 2-bit slice pair per clock, MSB slice first. It resolves greater/lesser/equal and reports the result with a one-cycle done pulse. It sits directly upstream of `comp_gate`, sequencing its `a`/`b` inputs and consuming its `greater`/`lesser`/`equal` outputs.

## Interface
- WIDTH, 8: operand width; must be even and ≥ 2; slice count S = WIDTH/2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge
- b  input  WIDTH  operand B; sampled on the accepting edge
- busy  output  1  high in CMP and DONE
- done  output  1  one-cycle pulse; result valid
- greater  output  1  A > B (registered, held)
- lesser  output  1  A < B (registered, held)
- equal  output  1  A == B (registered, held)

## Operation
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- States: IDLE, CMP, DONE.
- IDLE: if start=1 at an edge, capture a/b into internal registers, set idx=S-1, clear greater/lesser/equal, go to CMP. Otherwise remain in IDLE.
- CMP: `comp_gate` sees a_reg[2*idx+1:2*idx] and b_reg[2*idx+1:2*idx] combinationally. At each edge:
  - If the slice is unequal, latch the slice's greater/lesser and go to DONE.
  - Else if idx==0, set equal=1 and go to DONE.
  - Else decrement idx.
- DONE: done=1 for exactly this cycle, then return to IDLE unconditionally.
- start is ignored in CMP and DONE. No queuing; a dropped request is not remembered.
- Results are one-hot once done has pulsed. They hold their value until the next accepted start clears them.
- idx width: max(1, $clog2(S)). idx never wraps; the idx==0 check terminates the scan.
- Reset, including mid-operation: state=IDLE; busy, done, greater, lesser and equal all go to 0; idx and operand registers go to 0.
- rst has priority over start on the same edge.

## Timing
- Edge 0: start accepted.
- Edge k (1 ≤ k ≤ S): decision made on the k-th slice examined.
- done and valid results are high in the cycle following edge k.
- Latency from start to done: k+1 edges. Worst case is S+1; best case is 2.
- busy rises the cycle after edge 0 and falls in the cycle after the DONE edge.
- Back-to-back throughput: one new start can be accepted in the first IDLE cycle after DONE.

## Configuration
- SERIAL_COMP_EARLY_EXIT_EN defined: behaviour as above; the scan stops at the first unequal slice, so latency depends on the data.
- Not defined: the scan always covers all S slices, so latency is S+1 regardless of data.
  - A sticky "decided" flag freezes the result from the first unequal slice.
  - Later slices are ignored.
  - equal=1 only if no slice differed.

## Structure
- Shared package/include holds:
  - State encodings: IDLE=2'b00, CMP=2'b01, DONE=2'b10.
  - The slice-width constant 2.
- One sub-module instance: `comp_gate` (existing 2-bit comparator), driven by the current slice pair.
- All other logic (FSM, idx counter, operand and result registers) is local to `serial_comp_seq`.

## Test plan
All scenarios use WIDTH=8 (S=4).
- a=8'hA5, b=8'hA5, start at edge 0 -> equal=1, greater=lesser=0; done in the cycle after edge 4.
- a=8'h80, b=8'h7F, with early exit -> greater=1, done in the cycle after edge 1. Without the macro -> greater=1, done in the cycle after edge 4.
- a=8'h12, b=8'h13 -> lesser=1 at the last slice; done in the cycle after edge 4.
- Start pulse held during CMP with different operands -> ignored; the first result is unchanged and done pulses exactly once.
- rst asserted at edge 2 of a compare -> next cycle all outputs are 0 and state is IDLE; a new start (a=8'h03, b=8'h01) then yields greater=1.
- Two back-to-back compares (8'h00 vs 8'hFF, then 8'hFF vs 8'h00) -> lesser, then greater. Results are cleared at the second start and done pulses once per compare.
